// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, FSM states,
// instruction classes and the datapath mux select codes.
package rv_ctrl_pkg;

    // Major opcodes (instr[6:0]); the immediate generator decodes the same values.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    // CLS_OP is the all-zero value so the reset class is a harmless default.
    typedef enum logic [3:0] {
        CLS_OP     = 4'd0,
        CLS_OPIMM  = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_JAL    = 4'd5,
        CLS_JALR   = 4'd6,
        CLS_LUI    = 4'd7,
        CLS_AUIPC  = 4'd8
    } op_class_t;

    // pc_sel
    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    // alu_a_sel / alu_b_sel
    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;
    localparam logic       B_RS2  = 1'b0;
    localparam logic       B_IMM  = 1'b1;

    // wb_sel
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // ALU operand pair {alu_a_sel, alu_b_sel} for a class; branches and JAL
    // fall to rs1/rs2 since their targets come from the dedicated pc+imm adder.
    function automatic logic [2:0] operand_sel(op_class_t c);
        case (c)
            CLS_OP:                                  return {A_RS1, B_RS2};
            CLS_OPIMM, CLS_LOAD, CLS_STORE, CLS_JALR: return {A_RS1, B_IMM};
            CLS_LUI:                                 return {A_ZERO, B_IMM};
            CLS_AUIPC:                               return {A_PC, B_IMM};
            default:                                 return {A_RS1, B_RS2};
        endcase
    endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Memory request/ready handshake between the controller (master) and memory (slave).
interface rv_multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_is_fetch;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_is_fetch, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_is_fetch, output mem_ready);
endinterface

// File: rtl/rv_op_decode.sv
// Combinational opcode classifier: maps instr[6:0] to an instruction class and
// flags anything outside the supported RV32I subset as illegal.
module rv_op_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class,
    output logic       illegal
);

    // Opcode lookup; unknown encodings raise illegal and report CLS_OP.
    always_comb begin
        op_class = CLS_OP;
        illegal  = 1'b0;
        case (opcode)
            OPC_OP:     op_class = CLS_OP;
            OPC_OPIMM:  op_class = CLS_OPIMM;
            OPC_LOAD:   op_class = CLS_LOAD;
            OPC_STORE:  op_class = CLS_STORE;
            OPC_BRANCH: op_class = CLS_BRANCH;
            OPC_JAL:    op_class = CLS_JAL;
            OPC_JALR:   op_class = CLS_JALR;
            OPC_LUI:    op_class = CLS_LUI;
            OPC_AUIPC:  op_class = CLS_AUIPC;
            default:    illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core. One instruction at a time walks
// FETCH -> DECODE -> EXEC [-> MEM] [-> WB]; only the last state of an
// instruction writes the PC, so the PC holds the instruction address throughout.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   ST_FETCH  | request instruction at PC, latch IR on mem_ready
//   ST_DECODE | register instruction class, illegal opcode -> ST_TRAP
//   ST_EXEC   | drive ALU operands; branch/JAL/JALR finish here
//   ST_MEM    | load/store data access; store finishes on mem_ready
//   ST_WB     | register-file write and PC += 4
//   ST_TRAP   | sticky fault (illegal opcode or memory timeout), left only by rst
//
// Outputs are decoded combinationally from state (plus br_taken/mem_ready)
// and forced low while rst is high.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int RET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    rv_multicycle_ctrl_if.master mem,
    input  logic [6:0]           opcode,
    input  logic                 br_taken,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic [1:0]           alu_a_sel,
    output logic                 alu_b_sel,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic                 trap,
    output logic [RET_W-1:0]     retired
);

    localparam int             CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    op_class_t        cls;
    op_class_t        dec_class;
    logic             dec_illegal;
    logic [CNT_W-1:0] wait_cnt;

    logic req;
    logic req_we;
    logic req_fetch;

    rv_op_decode u_op_decode (
        .opcode   (opcode),
        .op_class (dec_class),
        .illegal  (dec_illegal)
    );

    assign mem.mem_req      = req;
    assign mem.mem_we       = req_we;
    assign mem.mem_is_fetch = req_fetch;

    // Datapath controls and memory request decoded from the current state.
    always_comb begin
        req       = 1'b0;
        req_we    = 1'b0;
        req_fetch = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        alu_a_sel = A_RS1;
        alu_b_sel = B_RS2;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        trap      = 1'b0;
        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    req       = 1'b1;
                    req_fetch = 1'b1;
                    ir_we     = mem.mem_ready;
                end
                ST_EXEC: begin
                    {alu_a_sel, alu_b_sel} = operand_sel(cls);
                    case (cls)
                        CLS_BRANCH: begin
                            pc_we  = 1'b1;
                            pc_sel = br_taken ? PC_IMM : PC_PLUS4;
                        end
                        CLS_JAL: begin
                            rf_we  = 1'b1;
                            wb_sel = WB_PC4;
                            pc_we  = 1'b1;
                            pc_sel = PC_IMM;
                        end
                        CLS_JALR: begin
                            rf_we  = 1'b1;
                            wb_sel = WB_PC4;
                            pc_we  = 1'b1;
                            pc_sel = PC_JALR;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    // Operands stay as in EXEC so the address is stable during the access.
                    {alu_a_sel, alu_b_sel} = operand_sel(cls);
                    req    = 1'b1;
                    req_we = (cls == CLS_STORE);
                    pc_we  = (cls == CLS_STORE) && mem.mem_ready;
                end
                ST_WB: begin
                    // Operands stay as in EXEC so the ALU result feeding writeback is stable.
                    {alu_a_sel, alu_b_sel} = operand_sel(cls);
                    rf_we  = 1'b1;
                    wb_sel = (cls == CLS_LOAD) ? WB_MEM : WB_ALU;
                    pc_we  = 1'b1;
                end
                ST_TRAP: trap = 1'b1;
                default: ;
            endcase
        end
    end

    // State, class, memory-wait counter and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FETCH;
            cls      <= CLS_OP;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            if (pc_we) begin
                retired <= retired + RET_W'(1);
            end
            case (state)
                ST_FETCH: begin
                    if (mem.mem_ready) begin
                        wait_cnt <= '0;
                        state    <= ST_DECODE;
                    end else if (wait_cnt == TO_LAST) begin
                        state <= ST_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_DECODE: begin
                    cls   <= dec_class;
                    state <= dec_illegal ? ST_TRAP : ST_EXEC;
                end
                ST_EXEC: begin
                    case (cls)
                        CLS_BRANCH, CLS_JAL, CLS_JALR: begin
                            wait_cnt <= '0;
                            state    <= ST_FETCH;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            wait_cnt <= '0;
                            state    <= ST_MEM;
                        end
                        default: state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (mem.mem_ready) begin
                        wait_cnt <= '0;
                        state    <= (cls == CLS_STORE) ? ST_FETCH : ST_WB;
                    end else if (wait_cnt == TO_LAST) begin
                        state <= ST_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_WB: begin
                    wait_cnt <= '0;
                    state    <= ST_FETCH;
                end
                ST_TRAP: state <= ST_TRAP;
                default: state <= ST_TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: the driver plays memory and pushes
// the predicted outcome of each instruction; an independent monitor watches
// the outputs, times each instruction and compares at its completion/trap.
module tb_rv_multicycle_ctrl;

    localparam int TIMEOUT = 4;
    localparam int RET_W   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [6:0]       opcode = 7'd0;
    logic             br_taken = 1'b0;
    logic             ir_we, pc_we, alu_b_sel, rf_we, trap;
    logic [1:0]       pc_sel, alu_a_sel, wb_sel;
    logic [RET_W-1:0] retired;

    rv_multicycle_ctrl_if bus ();

    rv_multicycle_ctrl #(.TIMEOUT(TIMEOUT), .RET_W(RET_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem       (bus),
        .opcode    (opcode),
        .br_taken  (br_taken),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .alu_a_sel (alu_a_sel),
        .alu_b_sel (alu_b_sel),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .trap      (trap),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int lat;       // cycles from first FETCH cycle to completion/trap cycle
        bit trap;
        int pc_sel;
        bit rf_we;
        int wb_sel;
        int exec_cyc;
        bit exec_chk;
        int a_sel;
        int b_sel;
        bit is_store;
        int ret;       // retired value visible during the completion cycle
    } exp_t;

    exp_t exp_q[$];
    int   model_ret = 0;

    // Reference model: instruction timing and final controls from the ISA-level rules.
    function automatic exp_t predict(input bit [6:0] op, input int fw, input int dw, input bit bt);
        exp_t e;
        e = '{default: 0};
        e.ret      = model_ret % (1 << RET_W);
        e.exec_cyc = fw + 3;
        if (fw >= TIMEOUT) begin
            e.trap = 1; e.lat = TIMEOUT + 1;
            return e;
        end
        case (op)
            7'b0110011: begin e.rf_we = 1; e.lat = fw + 4; e.exec_chk = 1; e.a_sel = 0; e.b_sel = 0; end
            7'b0010011: begin e.rf_we = 1; e.lat = fw + 4; e.exec_chk = 1; e.a_sel = 0; e.b_sel = 1; end
            7'b0110111: begin e.rf_we = 1; e.lat = fw + 4; e.exec_chk = 1; e.a_sel = 2; e.b_sel = 1; end
            7'b0010111: begin e.rf_we = 1; e.lat = fw + 4; e.exec_chk = 1; e.a_sel = 1; e.b_sel = 1; end
            7'b1100011: begin e.lat = fw + 3; e.pc_sel = bt ? 1 : 0; end
            7'b1101111: begin e.lat = fw + 3; e.rf_we = 1; e.wb_sel = 2; e.pc_sel = 1; end
            7'b1100111: begin e.lat = fw + 3; e.rf_we = 1; e.wb_sel = 2; e.pc_sel = 2;
                              e.exec_chk = 1; e.a_sel = 0; e.b_sel = 1; end
            7'b0000011: begin
                e.exec_chk = 1; e.a_sel = 0; e.b_sel = 1;
                if (dw >= TIMEOUT) begin e.trap = 1; e.lat = fw + 4 + TIMEOUT; end
                else begin e.lat = fw + 5 + dw; e.rf_we = 1; e.wb_sel = 1; end
            end
            7'b0100011: begin
                e.exec_chk = 1; e.a_sel = 0; e.b_sel = 1; e.is_store = 1;
                if (dw >= TIMEOUT) begin e.trap = 1; e.lat = fw + 4 + TIMEOUT; end
                else e.lat = fw + 4 + dw;
            end
            default: begin e.trap = 1; e.lat = fw + 3; end
        endcase
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_ret = 0;
    endtask

    // Serve one memory request: mem_ready after `waits` idle cycles.
    task automatic serve(input int waits);
        for (int k = 0; k <= waits; k++) begin
            bus.mem_ready = (k == waits);
            @(negedge clk);
        end
        bus.mem_ready = 1'b0;
    endtask

    // Issue one instruction from a negedge where the DUT sits in FETCH.
    task automatic run(input bit [6:0] op, input int fw, input int dw, input bit bt);
        exp_t e;
        bit is_mem, is_load, single, legal;
        e = predict(op, fw, dw, bt);
        exp_q.push_back(e);
        if (!e.trap) model_ret++;
        is_load = (op == 7'b0000011);
        is_mem  = is_load || (op == 7'b0100011);
        single  = (op == 7'b1100011) || (op == 7'b1101111) || (op == 7'b1100111);
        legal   = is_mem || single || (op == 7'b0110011) || (op == 7'b0010011) ||
                  (op == 7'b0110111) || (op == 7'b0010111);
        opcode   = op;
        br_taken = bt;
        serve(fw);
        if (fw < TIMEOUT) begin
            @(negedge clk);                        // DECODE
            if (legal) begin
                @(negedge clk);                    // EXEC
                if (is_mem) begin
                    serve(dw);
                    if (is_load && dw < TIMEOUT) @(negedge clk);  // WB
                end else if (!single) begin
                    @(negedge clk);                // WB
                end
            end
        end
        if (e.trap) begin
            repeat (20) @(negedge clk);
            do_reset();
        end
    endtask

    // Monitor: samples just after the falling edge, once inputs for the next edge are set.
    initial begin
        bit   active = 0, trapped = 0, prev_rst = 0;
        int   cyc = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                active = 0; trapped = 0;
                chk("reset_outs", {bus.mem_req, bus.mem_we, bus.mem_is_fetch, ir_we, pc_we, pc_sel,
                                   alu_a_sel, alu_b_sel, rf_we, wb_sel, trap}, 0);
                if (prev_rst) chk("reset_retired", retired, 0);
                prev_rst = 1;
            end else begin
                prev_rst = 0;
                if (trapped) begin
                    chk("trap_sticky", {trap, bus.mem_req, pc_we, rf_we, ir_we}, 5'b10000);
                end else begin
                    if (!active && bus.mem_req && bus.mem_is_fetch) begin
                        if (exp_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL no_expectation instruction started with empty queue at %0t", $time);
                        end else begin
                            active = 1; cyc = 0;
                        end
                    end
                    if (active) begin
                        cyc++;
                        e = exp_q[0];
                        if (bus.mem_req && bus.mem_is_fetch) chk("ir_we", ir_we, bus.mem_ready);
                        if (e.exec_chk && cyc == e.exec_cyc) begin
                            chk("exec_a_sel", alu_a_sel, e.a_sel);
                            chk("exec_b_sel", alu_b_sel, e.b_sel);
                        end
                        if (bus.mem_req && !bus.mem_is_fetch) begin
                            chk("mem_we", bus.mem_we, e.is_store);
                            chk("mem_b_sel", alu_b_sel, 1);
                        end
                        if (pc_we || trap) begin
                            chk("latency", cyc, e.lat);
                            chk("trap", trap, e.trap);
                            chk("pc_sel", pc_sel, e.pc_sel);
                            chk("rf_we", rf_we, e.rf_we);
                            chk("wb_sel", wb_sel, e.wb_sel);
                            chk("retired", retired, e.ret);
                            void'(exp_q.pop_front());
                            active  = 0;
                            trapped = trap;
                        end else begin
                            chk("rf_we_idle", rf_we, 0);
                            if (cyc > 60) begin
                                checks++; errors++;
                                $display("FAIL hang no completion after %0d cycles, expected %0d", cyc, e.lat);
                                void'(exp_q.pop_front());
                                active = 0;
                            end
                        end
                    end
                end
            end
        end
    end

    bit [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    function automatic int pick_wait();
        return ($urandom_range(0, 14) == 0) ? int'($urandom_range(TIMEOUT, TIMEOUT + 2))
                                            : int'($urandom_range(0, TIMEOUT - 1));
    endfunction

    // Stimulus: directed cases first, then randomized instruction stream.
    initial begin
        bus.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run(7'b0010011, 0, 0, 0);      // ADDI, 4 cycles
        run(7'b0000011, 2, 3, 0);      // LW, 10 cycles
        run(7'b1100011, 0, 0, 1);      // BEQ taken
        run(7'b1100011, 0, 0, 0);      // BEQ not taken
        run(7'b1100111, 0, 0, 0);      // JALR
        run(7'b1101111, 1, 0, 0);      // JAL
        run(7'b0110111, 0, 0, 0);      // LUI
        run(7'b0010111, 0, 0, 0);      // AUIPC
        run(7'b0110011, 3, 0, 0);      // OP, fetch ready on the limit cycle
        run(7'b0000000, 0, 0, 0);      // illegal -> trap, reset
        run(7'b0100011, 0, 10, 0);     // SW never ready -> timeout trap
        run(7'b0100011, 0, 3, 0);      // SW ready on 4th cycle completes
        run(7'b0010011, 4, 0, 0);      // fetch timeout
        for (int i = 0; i < 160; i++) begin
            bit [6:0] op;
            if ($urandom_range(0, 11) == 0) op = 7'($urandom_range(0, 127));
            else                            op = legal_ops[$urandom_range(0, 8)];
            run(op, pick_wait(), pick_wait(), 1'($urandom_range(0, 1)));
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
